// File: rtl/keypad_number_entry_if.sv
// Keypad matrix pins and the converted-number result bus of keypad_number_entry.
interface keypad_number_entry_if #(
   parameter int DIGITS = 3,
   parameter int WIDTH  = 8
);
   localparam int CNT_W = $clog2(DIGITS + 1);

   logic [3:0]       row;
   logic [3:0]       col;
   logic [WIDTH-1:0] out;
   logic             out_valid;
   logic             overflow;
   logic             neg;
   logic             busy;
   logic [CNT_W-1:0] digit_count;

   modport slave  (input row, output col, out, out_valid, overflow, neg, busy, digit_count);
   modport master (output row, input col, out, out_valid, overflow, neg, busy, digit_count);
endinterface

// File: rtl/keypad_number_entry.sv
// 4x4 keypad scanner with debounce, signed decimal entry buffer and
// serial BCD-to-binary conversion with saturation to a WIDTH-bit result.
module keypad_number_entry #(
   parameter int DIGITS   = 3,
   parameter int WIDTH    = 8,
   parameter int SCAN_DIV = 4,
   parameter int DEBOUNCE = 2
) (
   input logic                  clk,
   input logic                  reset,
   keypad_number_entry_if.slave kp
);
   localparam int CNT_W = $clog2(DIGITS + 1);
   localparam int DIV_W = $clog2(SCAN_DIV);
   localparam int DB_W  = $clog2(DEBOUNCE + 1);
   localparam int ACC_W = $clog2(10 ** DIGITS);

   localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(SCAN_DIV - 1);
   localparam logic [DB_W-1:0]  DB_MAX    = DB_W'(DEBOUNCE);
   localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(DIGITS);
   localparam logic [CNT_W-1:0] CONV_LAST = CNT_W'(DIGITS - 1);

   localparam logic [1:0] ENTRY = 2'd0;
   localparam logic [1:0] CONV  = 2'd1;
   localparam logic [1:0] OUT   = 2'd2;

   // key code is {row, col}
   localparam logic [3:0] K_A    = 4'h3;
   localparam logic [3:0] K_B    = 4'h7;
   localparam logic [3:0] K_STAR = 4'hC;
   localparam logic [3:0] K_ZERO = 4'hD;
   localparam logic [3:0] K_HASH = 4'hE;

   // ---------------- column scan ----------------
   logic [DIV_W-1:0] div_cnt;
   logic [1:0]       col_idx;
   logic             slot_end, frame_end;
   logic             fr_hit;
   logic [3:0]       fr_key;
   logic             row_any, cur_hit;
   logic [1:0]       row_first;
   logic [3:0]       cur_key;

   assign slot_end  = (div_cnt == DIV_LAST);
   assign frame_end = slot_end && (col_idx == 2'd3);
   assign kp.col    = ~(4'b0001 << col_idx);
   assign row_any   = (kp.row != 4'hF);

   always_comb begin
      row_first = 2'd0;
      for (int i = 3; i >= 0; i--)
         if (!kp.row[i]) row_first = 2'(i);
   end

   // frame result including the column being sampled right now
   assign cur_hit = fr_hit | row_any;
   assign cur_key = fr_hit ? fr_key : {row_first, col_idx};

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         div_cnt <= '0;
         col_idx <= 2'd0;
         fr_hit  <= 1'b0;
         fr_key  <= 4'h0;
      end else if (slot_end) begin
         div_cnt <= '0;
         col_idx <= col_idx + 2'd1;
         if (frame_end) begin
            fr_hit <= 1'b0;
            fr_key <= 4'h0;
         end else if (!fr_hit && row_any) begin
            fr_hit <= 1'b1;
            fr_key <= {row_first, col_idx};
         end
      end else begin
         div_cnt <= div_cnt + DIV_W'(1);
      end
   end

   // ---------------- debounce ----------------
   logic [3:0]      db_key;
   logic [DB_W-1:0] db_cnt, db_cnt_nxt;
   logic            db_lock;
   logic            key_evt;
   logic [3:0]      evt_key;
   logic            db_same;

   assign db_same = (db_cnt != '0) && (cur_key == db_key);

   always_comb begin
      db_cnt_nxt = DB_W'(1);
      if (db_same) db_cnt_nxt = (db_cnt == DB_MAX) ? db_cnt : db_cnt + DB_W'(1);
   end

   // db_lock blocks auto-repeat until an empty frame is seen
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         db_key  <= 4'h0;
         db_cnt  <= '0;
         db_lock <= 1'b0;
         key_evt <= 1'b0;
         evt_key <= 4'h0;
      end else begin
         key_evt <= 1'b0;
         if (frame_end) begin
            if (!cur_hit) begin
               db_cnt  <= '0;
               db_lock <= 1'b0;
            end else begin
               db_key <= cur_key;
               db_cnt <= db_cnt_nxt;
               if (db_cnt_nxt == DB_MAX && !db_lock) begin
                  key_evt <= 1'b1;
                  evt_key <= cur_key;
                  db_lock <= 1'b1;
               end
            end
         end
      end
   end

   // ---------------- entry / conversion ----------------
   logic [1:0]             state;
   logic [DIGITS-1:0][3:0] bcd;
   logic [CNT_W-1:0]       cnt, conv_idx;
   logic [ACC_W-1:0]       acc, acc_nxt;
   logic                   neg_r, ovf_r, vld_r;
   logic [WIDTH-1:0]       out_r, sat_out;
   logic                   sat_ov;
   logic                   is_digit;
   logic [3:0]             digit_val;
   logic [63:0]            mag, lim_pos;

   assign is_digit  = ((evt_key[3:2] != 2'd3) && (evt_key[1:0] != 2'd3)) || (evt_key == K_ZERO);
   assign digit_val = (evt_key == K_ZERO) ? 4'd0 :
                      {2'b00, evt_key[3:2]} * 4'd3 + {2'b00, evt_key[1:0]} + 4'd1;

   // slots beyond the entered count leave acc untouched
   assign acc_nxt = (conv_idx < cnt) ? acc * ACC_W'(10) + ACC_W'(bcd[conv_idx]) : acc;

   always_comb begin
      mag     = 64'(acc_nxt);
      lim_pos = (64'd1 << (WIDTH - 1)) - 64'd1;
      if (neg_r) begin
         sat_ov  = (mag > lim_pos + 64'd1);
         sat_out = sat_ov ? {1'b1, {(WIDTH-1){1'b0}}} : WIDTH'(64'd0 - mag);
      end else begin
         sat_ov  = (mag > lim_pos);
         sat_out = sat_ov ? WIDTH'(lim_pos) : WIDTH'(mag);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= ENTRY;
         bcd      <= '0;
         cnt      <= '0;
         neg_r    <= 1'b0;
         conv_idx <= '0;
         acc      <= '0;
         out_r    <= '0;
         ovf_r    <= 1'b0;
         vld_r    <= 1'b0;
      end else begin
         vld_r <= 1'b0;
         case (state)
            ENTRY: if (key_evt) begin
               if (is_digit) begin
                  if (cnt != CNT_MAX) begin
                     bcd[cnt] <= digit_val;
                     cnt      <= cnt + CNT_W'(1);
                  end
               end else if (evt_key == K_STAR) begin
                  neg_r <= ~neg_r;
               end else if (evt_key == K_A) begin
                  bcd   <= '0;
                  cnt   <= '0;
                  neg_r <= 1'b0;
               end else if (evt_key == K_B) begin
                  if (cnt != '0) cnt <= cnt - CNT_W'(1);
               end else if (evt_key == K_HASH) begin
                  state    <= CONV;
                  conv_idx <= '0;
                  acc      <= '0;
               end
            end
            CONV: begin
               acc      <= acc_nxt;
               conv_idx <= conv_idx + CNT_W'(1);
               if (conv_idx == CONV_LAST) begin
                  state <= OUT;
                  out_r <= sat_out;
                  ovf_r <= sat_ov;
                  vld_r <= 1'b1;
               end
            end
            OUT: begin
               state <= ENTRY;
               bcd   <= '0;
               cnt   <= '0;
               neg_r <= 1'b0;
            end
            default: state <= ENTRY;
         endcase
      end
   end

   assign kp.out         = out_r;
   assign kp.out_valid   = vld_r;
   assign kp.overflow    = ovf_r;
   assign kp.neg         = neg_r;
   assign kp.busy        = (state == CONV);
   assign kp.digit_count = cnt;
endmodule

// File: tb/tb_keypad_number_entry.sv
// Directed bench for keypad_number_entry: a keypad model drives rows from the
// scanned columns; conversions, debounce and reset abort are checked.
module tb_keypad_number_entry;
   localparam int FR = 16;

   logic       clk = 1'b0;
   logic       reset;
   logic       pressed;
   logic [3:0] kc;
   int         total = 0, bad = 0;
   int         cyc = 0;
   int         pulses = 0, vhigh = 0, vcyc = 0, bstart = 0, blen = 0;
   logic       v_prev = 1'b0, b_prev = 1'b0;

   keypad_number_entry_if #(.DIGITS(3), .WIDTH(8)) ifc ();

   keypad_number_entry #(.DIGITS(3), .WIDTH(8), .SCAN_DIV(4), .DEBOUNCE(2)) dut (
      .clk   (clk),
      .reset (reset),
      .kp    (ifc)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   assign ifc.row = (pressed && !ifc.col[kc[1:0]]) ? ~(4'b0001 << kc[3:2]) : 4'hF;

   always @(negedge clk) begin
      if (ifc.out_valid) begin
         vhigh++;
         if (!v_prev) begin pulses++; vcyc = cyc; end
      end
      if (ifc.busy) begin
         if (!b_prev) begin bstart = cyc; blen = 1; end
         else blen++;
      end
      v_prev = ifc.out_valid;
      b_prev = ifc.busy;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [3:0] kcode(input byte ch);
      string m;
      m = "123A456B789C*0#D";
      kcode = 4'h0;
      for (int i = 0; i < 16; i++) if (m[i] == ch) kcode = 4'(i);
   endfunction

   // returns #1 after the edge where col wraps from 0111 back to 1110
   task automatic sync_frame();
      logic [3:0] prev;
      logic       found;
      found = 1'b0;
      prev  = ifc.col;
      for (int n = 0; n < 64 && !found; n++) begin
         @(posedge clk); #1;
         if (ifc.col == 4'b1110 && prev == 4'b0111) found = 1'b1;
         prev = ifc.col;
      end
      if (!found) chk("frame_sync", {31'd0, found}, 32'd1);
   endtask

   task automatic hold(input byte ch, input int nfr);
      kc = kcode(ch);
      pressed = 1'b1;
      repeat (nfr * FR) @(posedge clk);
      #1;
   endtask

   task automatic press(input byte ch);
      sync_frame();
      hold(ch, 3);
      pressed = 1'b0;
   endtask

   task automatic press_str(input string s);
      for (int i = 0; i < s.len(); i++) press(s[i]);
   endtask

   task automatic conv(input string s, input logic [7:0] eo, input logic eov, input string tag);
      int p0, c0;
      p0 = pulses;
      c0 = vhigh;
      press_str(s);
      repeat (4) @(posedge clk);
      #1;
      chk({tag, "_out"}, {24'd0, ifc.out}, {24'd0, eo});
      chk({tag, "_ovf"}, {31'd0, ifc.overflow}, {31'd0, eov});
      chk({tag, "_pulses"}, pulses - p0, 1);
      chk({tag, "_vlen"}, vhigh - c0, 1);
      chk({tag, "_lat"}, vcyc - bstart, 3);
      chk({tag, "_busy"}, blen, 3);
      chk({tag, "_cnt"}, {30'd0, ifc.digit_count}, 0);
      chk({tag, "_neg"}, {31'd0, ifc.neg}, 0);
   endtask

   initial begin
      int p0;
      reset = 1'b0;
      pressed = 1'b0;
      kc = 4'h0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_col", {28'd0, ifc.col}, 32'hE);
      chk("rst_out", {24'd0, ifc.out}, 0);
      chk("rst_vld", {31'd0, ifc.out_valid}, 0);
      chk("rst_ovf", {31'd0, ifc.overflow}, 0);
      chk("rst_neg", {31'd0, ifc.neg}, 0);
      chk("rst_busy", {31'd0, ifc.busy}, 0);
      chk("rst_cnt", {30'd0, ifc.digit_count}, 0);
      @(negedge clk) reset = 1'b1;

      conv("123#", 8'h7B, 1'b0, "k123");
      press("*");
      chk("star_neg", {31'd0, ifc.neg}, 1);
      conv("128#", 8'h80, 1'b0, "m128");
      conv("*129#", 8'h80, 1'b1, "m129");
      conv("255#", 8'h7F, 1'b1, "p255");
      press("1");
      chk("hold_out", {24'd0, ifc.out}, 32'h7F);
      chk("hold_ovf", {31'd0, ifc.overflow}, 1);
      press("A");
      chk("clr_cnt", {30'd0, ifc.digit_count}, 0);
      conv("007#", 8'h07, 1'b0, "p007");

      press_str("456");
      chk("cnt_6", {30'd0, ifc.digit_count}, 3);
      press("7");
      chk("cnt_7", {30'd0, ifc.digit_count}, 3);
      press("B");
      chk("cnt_b", {30'd0, ifc.digit_count}, 2);
      conv("#", 8'h2D, 1'b0, "bksp");

      conv("#", 8'h00, 1'b0, "empty");
      conv("*0#", 8'h00, 1'b0, "negz");
      conv("*12A3#", 8'h03, 1'b0, "clr");
      conv("1C2D#", 8'h0C, 1'b0, "cd");

      // debounce: one frame is too short, a long hold gives one digit
      sync_frame();
      hold("5", 1);
      pressed = 1'b0;
      repeat (2 * FR) @(posedge clk);
      #1;
      chk("db_short", {30'd0, ifc.digit_count}, 0);
      sync_frame();
      hold("5", 10);
      pressed = 1'b0;
      repeat (2 * FR) @(posedge clk);
      #1;
      chk("db_long", {30'd0, ifc.digit_count}, 1);
      conv("#", 8'h05, 1'b0, "db5");

      sync_frame();
      hold("5", 1);
      hold("6", 1);
      hold("5", 1);
      pressed = 1'b0;
      repeat (2 * FR) @(posedge clk);
      #1;
      chk("glitch_none", {30'd0, ifc.digit_count}, 0);
      sync_frame();
      hold("5", 1);
      hold("6", 1);
      hold("5", 2);
      pressed = 1'b0;
      repeat (2 * FR) @(posedge clk);
      #1;
      chk("glitch_one", {30'd0, ifc.digit_count}, 1);
      conv("#", 8'h05, 1'b0, "gl5");

      // reset while converting 1,2,3
      press_str("123");
      p0 = pulses;
      fork
         press("#");
         begin : rst_br
            int n;
            n = 0;
            while (!ifc.busy && n < 400) begin @(negedge clk); n++; end
            if (!ifc.busy) chk("conv_seen", {31'd0, ifc.busy}, 1);
            #2;
            reset = 1'b0;
            pressed = 1'b0;
            #1;
            chk("abort_col", {28'd0, ifc.col}, 32'hE);
            chk("abort_out", {24'd0, ifc.out}, 0);
            chk("abort_busy", {31'd0, ifc.busy}, 0);
            chk("abort_cnt", {30'd0, ifc.digit_count}, 0);
            repeat (3) @(posedge clk);
            @(negedge clk) reset = 1'b1;
            repeat (3) @(posedge clk);
            #1;
            chk("rel_col0", {28'd0, ifc.col}, 32'hE);
            @(posedge clk);
            #1;
            chk("rel_col1", {28'd0, ifc.col}, 32'hD);
         end
      join
      repeat (3 * FR) @(posedge clk);
      #1;
      chk("abort_nopulse", pulses - p0, 0);
      chk("abort_out2", {24'd0, ifc.out}, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/keypad_number_entry.md
KEYPAD_NUMBER_ENTRY -- requirements
Module: keypad_number_entry

Interface
REQ-001 Parameter DIGITS, default 3: maximum decimal digits per entry, legal range 1..9.
REQ-002 Parameter WIDTH, default 8: result width, two's complement, legal range 4..32.
REQ-003 Parameter SCAN_DIV, default 4: clock cycles each column is driven, minimum 2.
REQ-004 Parameter DEBOUNCE, default 2: consecutive identical scan frames required to accept a key, minimum 1.
REQ-005 clk  input  1  single clock; all state changes on the rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 row  input  4  keypad rows, active-low, pre-synchronised externally.
REQ-008 col  output  4  keypad column drive, active-low, one-hot-zero.
REQ-009 out  output  WIDTH  last converted value, two's complement.
REQ-010 out_valid  output  1  one-cycle pulse when out is updated.
REQ-011 overflow  output  1  the last conversion saturated; updated together with out.
REQ-012 neg  output  1  current entry sign; 1 = negative.
REQ-013 busy  output  1  high while conversion is in progress.
REQ-014 digit_count  output  clog2(DIGITS+1)  number of digits currently buffered.

Function
REQ-015 Column scan sequence: col = 1110, 1101, 1011, 0111, repeating; each value is held SCAN_DIV cycles; 4*SCAN_DIV cycles make one frame.
REQ-016 row is sampled in the last cycle of each column slot; the frame result is the first low row in scan order (col0 row0, col0 row1, ... col3 row3), or "none".
REQ-017 Key map (row,col): (0,0..3)=1,2,3,A; (1,*)=4,5,6,B; (2,*)=7,8,9,C; (3,*)=*,0,#,D.
REQ-018 A key event (one-cycle internal strobe) fires when DEBOUNCE consecutive frames return the same key; no further event fires until at least one frame returns "none" (no auto-repeat).
REQ-019 A frame returning a different key restarts the debounce count at 1 for the new key.
REQ-020 Entry FSM states: ENTRY, CONV, OUT; reset state is ENTRY.
REQ-021 ENTRY, digit event: if digit_count < DIGITS, the digit is appended to the BCD buffer and digit_count increments; otherwise the digit is dropped.
REQ-022 ENTRY, '*' event: neg toggles.
REQ-023 ENTRY, 'A' event (clear): the buffer, digit_count and neg are all cleared.
REQ-024 ENTRY, 'B' event (backspace): the newest digit is removed and digit_count decrements; no effect when digit_count = 0; neg is unchanged.
REQ-025 ENTRY, '#' event at cycle t: state becomes CONV at t+1; busy is high from t+1 through t+DIGITS.
REQ-026 The C and D keys are ignored.
REQ-027 CONV lasts exactly DIGITS cycles and processes one buffered digit per cycle, oldest first: acc = acc*10 + digit; unused slots contribute nothing.
REQ-028 acc is wide enough to hold 10^DIGITS-1 without loss.
REQ-029 In cycle t+DIGITS+1 (state OUT): out, overflow and out_valid=1 are registered, then the state returns to ENTRY; the buffer, digit_count and neg clear at that same edge.
REQ-030 Saturation, positive: if acc > 2^(WIDTH-1)-1, out = 2^(WIDTH-1)-1 and overflow = 1.
REQ-031 Saturation, negative: if acc > 2^(WIDTH-1), out = -2^(WIDTH-1) and overflow = 1.
REQ-032 If no saturation occurs, out = acc or -acc according to neg, and overflow = 0.
REQ-033 A '#' with digit_count = 0 yields out = 0, overflow = 0, out_valid = 1.
REQ-034 A negative zero ("-0") yields out = 0.
REQ-035 Key events arriving during CONV or OUT are discarded; scanning and debounce continue uninterrupted.
REQ-036 out and overflow hold their values between conversions.

Reset
REQ-037 While reset is low: col = 1110; out = 0; out_valid = 0; overflow = 0; neg = 0; busy = 0; digit_count = 0; FSM = ENTRY; scan counters and debounce state are cleared.
REQ-038 Reset asserted mid-CONV aborts the conversion with no out_valid pulse; the first frame after release starts at col0.

Verification (DIGITS=3, WIDTH=8, SCAN_DIV=4, DEBOUNCE=2)
REQ-039 Keys 1,2,3,# -> out=0x7B, overflow=0, out_valid exactly one cycle, 4 cycles after the '#' event.
REQ-040 Keys *,1,2,8,# -> out=0x80, overflow=0; keys *,1,2,9,# -> out=0x80, overflow=1.
REQ-041 Keys 2,5,5,# -> out=0x7F, overflow=1; keys 0,0,7,# -> out=0x07, overflow=0.
REQ-042 Keys 4,5,6,7,B,# -> the 7 is dropped, the 6 is removed -> out=0x2D; digit_count reads 3,3,2 after the events for 6, 7 and B.
REQ-043 Key 5 low for 1 frame, then none -> no event; key 5 held for 10 frames -> exactly one digit; the same row/col glitching to a neighbour key for one frame restarts the debounce.
REQ-044 reset low during CONV of 1,2,3 -> out=0, out_valid never pulses, col=1110, digit_count=0.
